c2h_credit_tracker: RTL and testbench
=====================================

// Module: c2h_credit_tracker
// PURPOSE
//  Per-queue C2H descriptor-credit store sitting between the QDMA tm_dsc_sts status port and traffic_gen.
//  Accumulates descriptor availability reported per queue and grants or denies credit-consume
//  requests from the packet generator. Also exports a per-queue has-credit bitmap for queue scheduling.
// PARAMETERS
//  NQ          16  number of tracked queues (table depth); power of two, >=2
//  QID_W       11  queue id width
//  TM_DSC_BITS 16  width of tm_dsc_sts_avl and of consume count
//  CRDT_W      16  width of each per-queue credit counter (>= TM_DSC_BITS)
// PORTS
//  axi_aclk          in   1            clock
//  axi_areset        in   1            synchronous reset, active-high
//  tm_dsc_sts_vld    in   1            status update valid
//  tm_dsc_sts_qid    in   QID_W        queue of update
//  tm_dsc_sts_avl    in   TM_DSC_BITS  new descriptors made available
//  tm_dsc_sts_qen    in   1            queue enabled
//  tm_dsc_sts_dir    in   1            1 = C2H
//  tm_dsc_sts_mm     in   1            1 = MM (ignored traffic)
//  tm_dsc_sts_qinv   in   1            queue invalidated
//  tm_dsc_sts_error  in   1            update carries error
//  tm_dsc_sts_rdy    out  1            update accepted when vld&&rdy
//  qid_base          in   QID_W        first tracked qid
//  num_queue         in   QID_W        active queues (1..NQ)
//  flush             in   1            1-cycle pulse: zero all credits
//  crd_req_vld       in   1            consume request valid
//  crd_req_qid       in   QID_W        absolute qid to consume from
//  crd_req_num       in   TM_DSC_BITS  descriptors to consume
//  crd_req_rdy       out  1            request accepted when vld&&rdy
//  crd_rsp_vld       out  1            response pulse, 1 cycle after accept
//  crd_rsp_grant     out  1            1 = credit deducted, 0 = denied
//  crd_has_credit    out  NQ           bit i = credit[i] != 0 (registered)
//  err_ovf           out  1            sticky: credit saturated
//  err_qid           out  1            sticky: out-of-range qid seen
// BEHAVIOUR
//  States: INIT, IDLE. Reset -> INIT; flush pulse in IDLE -> INIT.
//  INIT: writes credit[idx]=0 for idx 0..NQ-1, one per cycle (NQ cycles), then IDLE.
//   tm_dsc_sts_rdy=0, crd_req_rdy=0 in INIT; any response pending at INIT entry is dropped (rsp_vld=0).
//  Reset values: all outputs 0, err_* cleared, crd_has_credit=0, idx=0. Only axi_areset clears err_*.
//  IDLE: tm_dsc_sts_rdy=1, crd_req_rdy=1; back-to-back accepts every cycle allowed.
//  In range: qid in [qid_base, qid_base+num_queue); local index = qid-qid_base (QID_W arithmetic,
//   no wrap: qid<qid_base is out of range). num_queue>NQ is treated as NQ.
//  Update filter on accept: ignore silently if dir=0 or mm=1 or error=1 or qen=0.
//   Out of range -> dropped, err_qid=1. qinv=1 in range -> credit[i]=0 (avl ignored).
//   Otherwise credit[i] += avl, saturating at 2^CRDT_W-1; saturation sets err_ovf.
//  Consume on accept: out of range -> grant=0, err_qid=1. num=0 -> grant=1, no change.
//   credit[i] >= num -> grant=1, credit[i] -= num; else grant=0, no change (no partial grant).
//  Decision uses credit value at start of accept cycle. Update and consume same queue same cycle:
//   grant decided on old value; new = sat(old - (grant?num:0) + avl); qinv wins (result 0, grant decided on old).
//  Credit table write latency 1 cycle; crd_has_credit reflects new value 1 cycle after accept.
//  crd_rsp_vld/grant valid exactly 1 cycle after accept, else rsp_vld=0.
//  flush in INIT is ignored; flush coincident with accept: accept discarded, INIT entered.
// TESTING
//  Reset, then hold 20 cycles -> rdy low NQ cycles, then rdy=1, has_credit=0, err_*=0.
//  qid_base=0,num_queue=4; avl=1024 to q0..q3 -> has_credit=4'hF; req q2 num=4 -> grant=1, q2 credit 1020.
//  q1 credit 3; req q1 num=4 -> grant=0, credit stays 3; req num=3 -> grant=1, has_credit[1]=0.
//  Same cycle: update q0 avl=8 and req q0 num=1030 (credit 1024) -> grant=0, credit 1032.
//  avl=16'hFFFF twice to q3 -> credit 16'hFFFF, err_ovf=1; update qid=5 -> dropped, err_qid=1.
//  flush mid-traffic -> NQ cycles rdy=0, all credits 0; err_* remain set; next req -> grant=0.

Source files
------------

// File: rtl/c2h_credit_tracker.sv
// Per-queue C2H descriptor-credit store: accumulates tm_dsc_sts availability,
// grants/denies consume requests and exports a registered has-credit bitmap.
module c2h_credit_tracker #(
  parameter int NQ          = 16,
  parameter int QID_W       = 11,
  parameter int TM_DSC_BITS = 16,
  parameter int CRDT_W      = 16
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic                   tm_dsc_sts_vld,
  input  logic [QID_W-1:0]       tm_dsc_sts_qid,
  input  logic [TM_DSC_BITS-1:0] tm_dsc_sts_avl,
  input  logic                   tm_dsc_sts_qen,
  input  logic                   tm_dsc_sts_dir,
  input  logic                   tm_dsc_sts_mm,
  input  logic                   tm_dsc_sts_qinv,
  input  logic                   tm_dsc_sts_error,
  output logic                   tm_dsc_sts_rdy,
  input  logic [QID_W-1:0]       qid_base,
  input  logic [QID_W-1:0]       num_queue,
  input  logic                   flush,
  input  logic                   crd_req_vld,
  input  logic [QID_W-1:0]       crd_req_qid,
  input  logic [TM_DSC_BITS-1:0] crd_req_num,
  output logic                   crd_req_rdy,
  output logic                   crd_rsp_vld,
  output logic                   crd_rsp_grant,
  output logic [NQ-1:0]          crd_has_credit,
  output logic                   err_ovf,
  output logic                   err_qid
);

  localparam int IDX_W = (NQ > 1) ? $clog2(NQ) : 1;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CRDT_W-1:0]      credit_q [NQ];
  logic [CRDT_W-1:0]      credit_d [NQ];
  logic                   rsp_vld_q, rsp_grant_q, err_ovf_q, err_qid_q;
  logic [NQ-1:0]          has_credit_q;

  logic                   go;
  logic [QID_W:0]         num_eff;
  logic [QID_W-1:0]       upd_off, req_off;
  logic                   upd_in, req_in, upd_ok, grant_c, ovf_hit, qid_bad;
  logic [IDX_W-1:0]       upd_idx, req_idx;
  logic [CRDT_W-1:0]      avl_ext, num_ext;
  logic [CRDT_W:0]        sum;

  assign go      = (state_q == S_IDLE) && !flush;
  assign num_eff = ({1'b0, num_queue} > (QID_W+1)'(NQ)) ? (QID_W+1)'(NQ) : {1'b0, num_queue};

  // qid < qid_base is out of range; the offset is only meaningful when in range
  assign upd_off = tm_dsc_sts_qid - qid_base;
  assign req_off = crd_req_qid - qid_base;
  assign upd_in  = (tm_dsc_sts_qid >= qid_base) && ({1'b0, upd_off} < num_eff);
  assign req_in  = (crd_req_qid >= qid_base) && ({1'b0, req_off} < num_eff);
  assign upd_idx = upd_off[IDX_W-1:0];
  assign req_idx = req_off[IDX_W-1:0];
  assign upd_ok  = tm_dsc_sts_dir && !tm_dsc_sts_mm && !tm_dsc_sts_error && tm_dsc_sts_qen;
  assign avl_ext = CRDT_W'(tm_dsc_sts_avl);
  assign num_ext = CRDT_W'(crd_req_num);

  assign grant_c = req_in && ((crd_req_num == '0) || (credit_q[req_idx] >= num_ext));
  assign qid_bad = go && ((tm_dsc_sts_vld && upd_ok && !upd_in) || (crd_req_vld && !req_in));

  always_comb begin
    ovf_hit = 1'b0;
    sum     = '0;
    for (int i = 0; i < NQ; i++) begin
      credit_d[i] = credit_q[i];
      if (go && crd_req_vld && grant_c && (req_idx == IDX_W'(i)))
        credit_d[i] = credit_q[i] - num_ext;
      if (go && tm_dsc_sts_vld && upd_ok && upd_in && (upd_idx == IDX_W'(i))) begin
        if (tm_dsc_sts_qinv) begin
          credit_d[i] = '0;
        end else begin
          sum = {1'b0, credit_d[i]} + {1'b0, avl_ext};
          if (sum[CRDT_W]) begin
            credit_d[i] = '1;
            ovf_hit     = 1'b1;
          end else begin
            credit_d[i] = sum[CRDT_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q      <= S_INIT;
      idx_q        <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_grant_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_qid_q    <= 1'b0;
      has_credit_q <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          credit_q[idx_q] <= '0;
          idx_q           <= idx_q + 1'b1;
          rsp_vld_q       <= 1'b0;
          rsp_grant_q     <= 1'b0;
          has_credit_q    <= '0;
          if (idx_q == IDX_W'(NQ-1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (flush) begin
            state_q      <= S_INIT;
            idx_q        <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_grant_q  <= 1'b0;
            has_credit_q <= '0;
          end else begin
            for (int i = 0; i < NQ; i++) begin
              credit_q[i]     <= credit_d[i];
              has_credit_q[i] <= (credit_d[i] != '0);
            end
            rsp_vld_q   <= crd_req_vld;
            rsp_grant_q <= crd_req_vld && grant_c;
            err_ovf_q   <= err_ovf_q | ovf_hit;
            err_qid_q   <= err_qid_q | qid_bad;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign tm_dsc_sts_rdy = (state_q == S_IDLE);
  assign crd_req_rdy    = (state_q == S_IDLE);
  assign crd_rsp_vld    = rsp_vld_q;
  assign crd_rsp_grant  = rsp_grant_q;
  assign crd_has_credit = has_credit_q;
  assign err_ovf        = err_ovf_q;
  assign err_qid        = err_qid_q;

endmodule

// File: tb/tb_c2h_credit_tracker.sv
// Directed, table-driven bench for c2h_credit_tracker (NQ=16 defaults).
module tb_c2h_credit_tracker;
  localparam int NQ = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sts_vld, sts_qen, sts_dir, sts_mm, sts_qinv, sts_error, sts_rdy;
  logic [10:0] sts_qid, qid_base, num_queue, req_qid;
  logic [15:0] sts_avl, req_num;
  logic        flush, req_vld, req_rdy, rsp_vld, rsp_grant, err_ovf, err_qid;
  logic [NQ-1:0] has_credit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  c2h_credit_tracker dut (
    .axi_aclk(clk), .axi_areset(rst),
    .tm_dsc_sts_vld(sts_vld), .tm_dsc_sts_qid(sts_qid), .tm_dsc_sts_avl(sts_avl),
    .tm_dsc_sts_qen(sts_qen), .tm_dsc_sts_dir(sts_dir), .tm_dsc_sts_mm(sts_mm),
    .tm_dsc_sts_qinv(sts_qinv), .tm_dsc_sts_error(sts_error), .tm_dsc_sts_rdy(sts_rdy),
    .qid_base(qid_base), .num_queue(num_queue), .flush(flush),
    .crd_req_vld(req_vld), .crd_req_qid(req_qid), .crd_req_num(req_num),
    .crd_req_rdy(req_rdy), .crd_rsp_vld(rsp_vld), .crd_rsp_grant(rsp_grant),
    .crd_has_credit(has_credit), .err_ovf(err_ovf), .err_qid(err_qid)
  );

  typedef struct {
    string       name;
    bit          uv;
    logic [10:0] uq;
    logic [15:0] avl;
    bit          qinv;
    bit          mm;
    bit          rv;
    logic [10:0] rq;
    logic [15:0] num;
    bit          e_rsp;
    bit          e_grant;
    logic [15:0] e_has;
    bit          e_ovf;
    bit          e_qid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string nm, bit uv, int uq, int avl, bit qinv, bit mm,
                     bit rv, int rq, int num, bit e_rsp, bit e_grant, int e_has,
                     bit e_ovf, bit e_qid);
    vec_t v;
    v.name = nm; v.uv = uv; v.uq = 11'(uq); v.avl = 16'(avl); v.qinv = qinv; v.mm = mm;
    v.rv = rv; v.rq = 11'(rq); v.num = 16'(num); v.e_rsp = e_rsp; v.e_grant = e_grant;
    v.e_has = 16'(e_has); v.e_ovf = e_ovf; v.e_qid = e_qid;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    sts_vld = 0; sts_qid = 0; sts_avl = 0; sts_qen = 1; sts_dir = 1; sts_mm = 0;
    sts_qinv = 0; sts_error = 0; flush = 0; req_vld = 0; req_qid = 0; req_num = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(int q, int avl);
    idle_inputs();
    sts_vld = 1; sts_qid = 11'(q); sts_avl = 16'(avl);
    tick();
  endtask

  task automatic req(int q, int num);
    idle_inputs();
    req_vld = 1; req_qid = 11'(q); req_num = 16'(num);
    tick();
  endtask

  // Counts cycles with rdy low, optionally pulsing flush during INIT.
  task automatic count_init(string nm, bit pulse_flush);
    int cnt = 0;
    while (!sts_rdy && cnt < 100) begin
      idle_inputs();
      if (pulse_flush && cnt == 3) flush = 1;
      cnt++;
      tick();
    end
    idle_inputs();
    chk({nm, "_init_cycles"}, cnt, NQ);
  endtask

  initial begin
    idle_inputs();
    qid_base = 0; num_queue = 4;
    rst = 1;
    repeat (20) tick();
    chk("rst_sts_rdy", sts_rdy, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_has", has_credit, 0);
    chk("rst_rsp", rsp_vld, 0);
    chk("rst_errs", {err_ovf, err_qid}, 0);
    rst = 0;
    #1;
    count_init("boot", 0);
    chk("boot_rdy", {sts_rdy, req_rdy}, 2'b11);
    chk("boot_has", has_credit, 0);
    chk("boot_errs", {err_ovf, err_qid}, 0);

    //   name        uv uq avl    qi mm rv rq num   rsp gr has    ovf qid
    add("upd_q0",     1, 0, 1024,  0, 0, 0, 0, 0,    0, 0, 'h1,  0, 0);
    add("upd_q1",     1, 1, 1024,  0, 0, 0, 0, 0,    0, 0, 'h3,  0, 0);
    add("upd_q2",     1, 2, 1024,  0, 0, 0, 0, 0,    0, 0, 'h7,  0, 0);
    add("upd_q3",     1, 3, 1024,  0, 0, 0, 0, 0,    0, 0, 'hF,  0, 0);
    add("req_q2_4",   0, 0, 0,     0, 0, 1, 2, 4,    1, 1, 'hF,  0, 0);
    add("req_q2_rem", 0, 0, 0,     0, 0, 1, 2, 1020, 1, 1, 'hB,  0, 0);
    add("req_q2_emp", 0, 0, 0,     0, 0, 1, 2, 1,    1, 0, 'hB,  0, 0);
    add("req_q1_1021",0, 0, 0,     0, 0, 1, 1, 1021, 1, 1, 'hB,  0, 0);
    add("req_q1_4",   0, 0, 0,     0, 0, 1, 1, 4,    1, 0, 'hB,  0, 0);
    add("req_q1_3",   0, 0, 0,     0, 0, 1, 1, 3,    1, 1, 'h9,  0, 0);
    add("req_q1_0",   0, 0, 0,     0, 0, 1, 1, 0,    1, 1, 'h9,  0, 0);
    add("same_q0",    1, 0, 8,     0, 0, 1, 0, 1030, 1, 0, 'h9,  0, 0);
    add("req_q0_1032",0, 0, 0,     0, 0, 1, 0, 1032, 1, 1, 'h8,  0, 0);
    add("sat_q3_a",   1, 3, 'hFFFF,0, 0, 0, 0, 0,    0, 0, 'h8,  1, 0);
    add("sat_q3_b",   1, 3, 'hFFFF,0, 0, 0, 0, 0,    0, 0, 'h8,  1, 0);
    add("req_q3_max", 0, 0, 0,     0, 0, 1, 3, 'hFFFF,1,1, 'h0,  1, 0);
    add("upd_q5_oor", 1, 5, 10,    0, 0, 0, 0, 0,    0, 0, 'h0,  1, 1);
    add("upd_q0_5",   1, 0, 5,     0, 0, 0, 0, 0,    0, 0, 'h1,  1, 1);
    add("qinv_req",   1, 0, 7,     1, 0, 1, 0, 3,    1, 1, 'h0,  1, 1);
    add("req_q4_oor", 0, 0, 0,     0, 0, 1, 4, 0,    1, 0, 'h0,  1, 1);
    add("upd_mm",     1, 1, 9,     0, 1, 0, 0, 0,    0, 0, 'h0,  1, 1);

    foreach (vecs[k]) begin
      idle_inputs();
      sts_vld = vecs[k].uv; sts_qid = vecs[k].uq; sts_avl = vecs[k].avl;
      sts_qinv = vecs[k].qinv; sts_mm = vecs[k].mm;
      req_vld = vecs[k].rv; req_qid = vecs[k].rq; req_num = vecs[k].num;
      tick();
      chk({vecs[k].name, "_rsp"}, rsp_vld, vecs[k].e_rsp);
      chk({vecs[k].name, "_grant"}, rsp_grant, vecs[k].e_grant);
      chk({vecs[k].name, "_has"}, has_credit, vecs[k].e_has);
      chk({vecs[k].name, "_ovf"}, err_ovf, vecs[k].e_ovf);
      chk({vecs[k].name, "_qid"}, err_qid, vecs[k].e_qid);
    end

    // Flush coincident with a request: request discarded, INIT restarts.
    upd(0, 100);
    chk("pre_flush_has", has_credit, 16'h0001);
    idle_inputs();
    flush = 1; req_vld = 1; req_qid = 0; req_num = 1;
    tick();
    chk("flush_rdy", {sts_rdy, req_rdy}, 0);
    chk("flush_rsp", rsp_vld, 0);
    chk("flush_has", has_credit, 0);
    count_init("flush", 1);
    chk("flush_errs_kept", {err_ovf, err_qid}, 2'b11);
    req(0, 1);
    chk("post_flush_rsp", rsp_vld, 1);
    chk("post_flush_grant", rsp_grant, 0);
    chk("post_flush_has", has_credit, 0);

    // Non-zero base and num_queue clamped to NQ.
    qid_base = 100; num_queue = 20;
    upd(115, 2);
    chk("base_has15", has_credit, 16'h8000);
    req(116, 0);
    chk("base_oor_grant", {rsp_vld, rsp_grant}, 2'b10);
    req(99, 0);
    chk("base_below_grant", {rsp_vld, rsp_grant}, 2'b10);
    req(115, 2);
    chk("base_grant", {rsp_vld, rsp_grant}, 2'b11);
    chk("base_has_clr", has_credit, 0);
    idle_inputs();
    tick();
    chk("rsp_one_cycle", rsp_vld, 0);

    rst = 1;
    tick();
    rst = 0;
    chk("rst2_errs", {err_ovf, err_qid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
